// File: rtl/mem_dma_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dma_if
//  Description : picorv32-style native memory bus between the DMA initiator
//                (master) and a memory responder (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_dma_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_instr,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_instr,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_dma.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dma
//  Description : Word-copy DMA engine on the picorv32 native memory bus.
//                Copies len_words 32-bit words from src_addr to dst_addr,
//                one read then one write per word, with a dead cycle after
//                every completed bus access.
//                Optional macro MEM_DMA_FILL_EN adds a fill mode that writes
//                a constant value to the destination without reading.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_dma #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
`ifdef MEM_DMA_FILL_EN
    input  logic             fill_mode,
    input  logic [31:0]      fill_value,
`endif
    output logic             busy,
    output logic             done,
    mem_dma_if.master        mem
);

    localparam logic [LEN_W-1:0] c_len_one  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]      c_word_inc = 32'd4;
    localparam logic [31:0]      c_align    = 32'hFFFF_FFFC;
    localparam logic [3:0]       c_strb_wr  = 4'b1111;
    localparam logic [3:0]       c_strb_rd  = 4'b0000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_WRITE  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t           r_state;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [31:0]      r_data;
    logic [31:0]      r_addr;
    logic [LEN_W-1:0] r_count;
    logic             r_valid;
    logic [3:0]       r_wstrb;
    logic             r_busy;
    logic             r_done;
    logic [1:0]       r_settle;
    logic             r_fill;

    logic             w_fill_req;
    logic [31:0]      w_fill_value;
    logic [31:0]      w_src_aligned;
    logic [31:0]      w_dst_aligned;
    logic             w_last;

`ifdef MEM_DMA_FILL_EN
    assign w_fill_req   = fill_mode;
    assign w_fill_value = fill_value;
`else
    assign w_fill_req   = 1'b0;
    assign w_fill_value = 32'd0;
`endif

    assign w_src_aligned = src_addr & c_align;
    assign w_dst_aligned = dst_addr & c_align;
    assign w_last        = (r_count == c_len_one);

    // Transfer sequencer: every bus-facing output is a register owned here.
    // A request is raised in the cycle after entering READ/WRITE, which
    // leaves the bus idle for one cycle after every handshake. Completion is
    // reported two cycles after the final write handshake.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state  <= S_IDLE;
            r_src    <= 32'd0;
            r_dst    <= 32'd0;
            r_data   <= 32'd0;
            r_addr   <= 32'd0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_wstrb  <= c_strb_rd;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_settle <= 2'd0;
            r_fill   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (len_words == '0) begin
                            // Empty copy: report completion straight away.
                            r_state  <= S_FINISH;
                            r_done   <= 1'b1;
                            r_settle <= 2'd0;
                        end else begin
                            r_src   <= w_src_aligned;
                            r_dst   <= w_dst_aligned;
                            r_count <= len_words;
                            r_busy  <= 1'b1;
                            r_fill  <= w_fill_req;
                            r_valid <= 1'b1;
                            if (w_fill_req) begin
                                r_state <= S_WRITE;
                                r_addr  <= w_dst_aligned;
                                r_wstrb <= c_strb_wr;
                                r_data  <= w_fill_value;
                            end else begin
                                r_state <= S_READ;
                                r_addr  <= w_src_aligned;
                                r_wstrb <= c_strb_rd;
                            end
                        end
                    end
                end

                S_READ: begin
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_addr  <= r_src;
                        r_wstrb <= c_strb_rd;
                    end else if (mem.mem_ready) begin
                        r_data  <= mem.mem_rdata;
                        r_valid <= 1'b0;
                        r_state <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_addr  <= r_dst;
                        r_wstrb <= c_strb_wr;
                    end else if (mem.mem_ready) begin
                        r_valid <= 1'b0;
                        r_src   <= r_src + c_word_inc;
                        r_dst   <= r_dst + c_word_inc;
                        r_count <= r_count - c_len_one;
                        if (w_last) begin
                            r_state  <= S_FINISH;
                            r_settle <= 2'd2;
                        end else if (r_fill) begin
                            r_state <= S_WRITE;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end

                S_FINISH: begin
                    if (r_done) begin
                        r_state <= S_IDLE;
                    end else if (r_settle > 2'd1) begin
                        r_settle <= r_settle - 2'd1;
                    end else begin
                        r_settle <= 2'd0;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign mem.mem_valid = r_valid;
    assign mem.mem_instr = 1'b0;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_data;
    assign mem.mem_wstrb = r_wstrb;

endmodule
`default_nettype wire
